// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch front-end bundle: redirect from Execute, instruction-memory request/response,
// and the Decode-side valid/ready handshake.
interface fetch_prefetch_buffer_if #(
  parameter int unsigned XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_plus4;

  // Fetch unit side.
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4
  );

  // Memory / Decode / Execute side.
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: credit-limited fetch requests, in-order response FIFO
// feeding Decode, and dropping of stale in-flight responses after a redirect.
module fetch_prefetch_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 4
) (
  input logic                     clk,
  input logic                     rst,
  fetch_prefetch_buffer_if.master bus
);

  localparam int unsigned     CntW = $clog2(DEPTH + 1);
  localparam int unsigned     PtrW = $clog2(DEPTH);
  localparam int unsigned     SumW = CntW + 2;
  localparam logic [XLEN-1:0] Inc  = XLEN'(PC_INC);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] fifoInstr [DEPTH];
  logic [XLEN-1:0] fifoPc    [DEPTH];
  logic [XLEN-1:0] sidePc    [DEPTH];
  logic [PtrW-1:0] fifoWr, fifoRd, sideWr, sideRd;
  logic [CntW-1:0] fifoCount, outCnt, dropCnt;

  logic [SumW-1:0] credits;
  logic            reqValid, issue, rspPush, rspDrop, decValid, decPop, redirect;

  // Every FIFO slot is reserved from request issue until Decode pops it, so a
  // response can never find the FIFO full.
  always_comb begin
    redirect = bus.redirect_valid;
    credits  = SumW'(fifoCount) + SumW'(outCnt) + SumW'(dropCnt);
    reqValid = rst && !redirect && (credits < SumW'(DEPTH));
    issue    = reqValid && bus.imem_req_ready;
    rspPush  = rst && bus.imem_rsp_valid && !redirect && (dropCnt == '0);
    rspDrop  = bus.imem_rsp_valid && (dropCnt != '0);
    decValid = fifoCount != '0;
    decPop   = decValid && bus.dec_ready;
  end

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPc;
  assign bus.dec_valid      = decValid;
  assign bus.dec_instr      = decValid ? fifoInstr[fifoRd] : '0;
  assign bus.dec_pc         = decValid ? fifoPc[fifoRd] : '0;
  assign bus.dec_pc_plus4   = decValid ? fifoPc[fifoRd] + Inc : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc   <= RESET_PC;
      fifoWr    <= '0;
      fifoRd    <= '0;
      sideWr    <= '0;
      sideRd    <= '0;
      fifoCount <= '0;
      outCnt    <= '0;
      dropCnt   <= '0;
    end else if (redirect) begin
      // A response landing in the redirect cycle belongs to the old stream.
      fetchPc   <= bus.redirect_pc;
      fifoWr    <= '0;
      fifoRd    <= '0;
      sideWr    <= '0;
      sideRd    <= '0;
      fifoCount <= '0;
      outCnt    <= '0;
      dropCnt   <= dropCnt + outCnt - CntW'(bus.imem_rsp_valid);
    end else begin
      if (issue) begin
        fetchPc <= fetchPc + Inc;
        sideWr  <= sideWr + 1'b1;
      end
      if (rspPush) begin
        sideRd <= sideRd + 1'b1;
        fifoWr <= fifoWr + 1'b1;
      end
      if (decPop) begin
        fifoRd <= fifoRd + 1'b1;
      end
      outCnt    <= outCnt + CntW'(issue) - CntW'(rspPush);
      dropCnt   <= dropCnt - CntW'(rspDrop);
      fifoCount <= fifoCount + CntW'(rspPush) - CntW'(decPop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (issue) begin
      sidePc[sideWr] <= fetchPc;
    end
    if (rspPush) begin
      fifoInstr[fifoWr] <= bus.imem_rsp_data;
      fifoPc[fifoWr]    <= sidePc[sideRd];
    end
  end

  fifoOverflow: assert property (@(posedge clk) disable iff (!rst)
    !(rspPush && (fifoCount == CntW'(DEPTH))));

  rspUnexpected: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_rsp_valid && (outCnt == '0) && (dropCnt == '0)));

endmodule
